// File: rtl/shift_unit.sv
// Purpose : multi-cycle barrel-lite shifter (SLL/SRL/SRA, ROL when SHIFT_UNIT_ROTATE_EN is defined), STEP bits per clock.
// Latency : out_valid rises ceil(shamt/STEP)+1 edges after acceptance, counting the acceptance edge (shamt 0 -> 1 edge).
// Backpressure: one request in flight; in_ready only in IDLE, the result is held in DONE until out_ready.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    // Largest per-cycle amount minus one; always fits in SHW bits since STEP <= WIDTH.
    localparam logic [SHW-1:0] STEP_M1 = SHW'(STEP - 1);

    state_t             state;
    logic [SHW-1:0]     remaining;
    logic [WIDTH-1:0]   data_q;
    logic               carry_q;
    logic [1:0]         mode_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [SHW-1:0]     step_amt;
    logic [1:0]         eff_mode;
    logic [WIDTH:0]     left_ext;
    logic [WIDTH:0]     srl_ext;
    logic [WIDTH:0]     sra_ext;
    logic [2*WIDTH-1:0] rol_ext;
    logic [WIDTH-1:0]   step_data;
    logic               step_carry;

    // Amount for this cycle: min(remaining, STEP). When STEP == WIDTH the first arm
    // is never taken because remaining tops out at WIDTH-1.
    always_comb begin
        step_amt = remaining;
        if (remaining > STEP_M1) begin
            step_amt = SHW'(STEP);
        end
    end

    // Without the rotate option, mode 11 is an alias of SLL in every respect.
    always_comb begin
`ifdef SHIFT_UNIT_ROTATE_EN
        eff_mode = mode_q;
`else
        eff_mode = (mode_q == MODE_ROL) ? MODE_SLL : mode_q;
`endif
    end

    // One step of shifting; an extra guard bit on each side catches the last bit out.
    always_comb begin
        left_ext   = {1'b0, data_q} << step_amt;
        srl_ext    = {data_q, 1'b0} >> step_amt;
        sra_ext    = $unsigned($signed({data_q, 1'b0}) >>> step_amt);
        rol_ext    = {data_q, data_q} << step_amt;
        step_data  = left_ext[WIDTH-1:0];
        step_carry = left_ext[WIDTH];
        case (eff_mode)
            MODE_SRL: begin
                step_data  = srl_ext[WIDTH:1];
                step_carry = srl_ext[0];
            end
            MODE_SRA: begin
                step_data  = sra_ext[WIDTH:1];
                step_carry = sra_ext[0];
            end
            MODE_ROL: begin
                step_data  = rol_ext[2*WIDTH-1:WIDTH];
                step_carry = 1'b0;
            end
            default: begin
                step_data  = left_ext[WIDTH-1:0];
                step_carry = left_ext[WIDTH];
            end
        endcase
    end

    // Control FSM with registered handshake outputs; data_q doubles as the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            data_q      <= '0;
            carry_q     <= 1'b0;
            mode_q      <= MODE_SLL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        mode_q     <= in_mode;
                        carry_q    <= 1'b0;
                        remaining  <= in_shamt;
                        in_ready_q <= 1'b0;
                        if (in_shamt == '0) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_q    <= step_data;
                    carry_q   <= step_carry;
                    remaining <= remaining - step_amt;
                    if (remaining == step_amt) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    remaining   <= '0;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign out_carry = carry_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit at WIDTH=32, STEP=4: results, carry, latency, hold and reset.
// Expected values are hand-computed; mode 11 expectations follow SHIFT_UNIT_ROTATE_EN.
// Every wait on the DUT is bounded; a global watchdog ends the run if anything stalls.
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int STEP  = 4;
    localparam int SHW   = $clog2(WIDTH);

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;

    int n_tests = 0;
    int n_fail  = 0;

    shift_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble inputs while busy, measure latency, optionally stall, then release.
    task automatic run_op(input string tag, input logic [31:0] d, input int sh, input logic [1:0] m,
                          input logic [31:0] exp_d, input logic exp_c, input int exp_lat, input int hold);
        int lat;
        logic [31:0] held;
        @(negedge clk);
        check({tag, ".ready_before"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = SHW'(sh);
        in_mode  = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_shamt = SHW'($urandom_range(0, WIDTH - 1));
        in_mode  = 2'($urandom_range(0, 3));
        lat = 1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) break;
            in_data = $urandom;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat++;
        end
        check({tag, ".out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".data"}, {32'd0, out_data}, {32'd0, exp_d});
        check({tag, ".carry"}, {63'd0, out_carry}, {63'd0, exp_c});
        held = out_data;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, ".hold_data"}, {32'd0, out_data}, {32'd0, held});
            check({tag, ".hold_ready"}, {63'd0, in_ready}, 64'd0);
            check({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
        end
        // Release with a shamt-0 request pending: it must not be taken on the release edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_shamt  = '0;
        in_mode   = 2'b00;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        check({tag, ".ready_after"}, {63'd0, in_ready}, 64'd1);
        check({tag, ".valid_after"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset.in_ready", {63'd0, in_ready}, 64'd1);
        check("reset.out_valid", {63'd0, out_valid}, 64'd0);
        check("reset.out_data", {32'd0, out_data}, 64'd0);
        check("reset.out_carry", {63'd0, out_carry}, 64'd0);

        run_op("sll_1_2",    32'h0000_0001, 2,  2'b00, 32'h0000_0004, 1'b0, 2, 0);
        run_op("sra_msb_31", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF, 1'b0, 9, 0);
        run_op("srl_1",      32'h8000_0001, 1,  2'b01, 32'h4000_0000, 1'b1, 2, 0);
        run_op("zero_sra",   32'h1234_5678, 0,  2'b10, 32'h1234_5678, 1'b0, 1, 0);
        run_op("zero_sll",   32'hDEAD_BEEF, 0,  2'b00, 32'hDEAD_BEEF, 1'b0, 1, 0);
        run_op("sll_f_4",    32'hF000_0000, 4,  2'b00, 32'h0000_0000, 1'b1, 2, 0);
        run_op("srl_f0_6",   32'h0000_00F0, 6,  2'b01, 32'h0000_0003, 1'b1, 3, 0);
        run_op("sra_pos_31", 32'h7FFF_FFFF, 31, 2'b10, 32'h0000_0000, 1'b1, 9, 0);
        run_op("sll_ones_31",32'hFFFF_FFFF, 31, 2'b00, 32'h8000_0000, 1'b1, 9, 0);
        run_op("hold5",      32'h0000_00A5, 3,  2'b00, 32'h0000_0528, 1'b0, 2, 5);
`ifdef SHIFT_UNIT_ROTATE_EN
        run_op("mode3_4",    32'h8000_0001, 4,  2'b11, 32'h0000_0018, 1'b0, 2, 0);
        run_op("mode3_8",    32'h1234_5678, 8,  2'b11, 32'h3456_7812, 1'b0, 3, 0);
`else
        run_op("mode3_4",    32'h8000_0001, 4,  2'b11, 32'h0000_0010, 1'b0, 2, 0);
        run_op("mode3_8",    32'h1234_5678, 8,  2'b11, 32'h3456_7800, 1'b0, 3, 0);
`endif

        // Reset while a long shift is in progress: request is dropped, no out_valid.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h8000_0000;
        in_shamt = SHW'(31);
        in_mode  = 2'b10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.in_ready", {63'd0, in_ready}, 64'd1);
        check("midrst.out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst.out_data", {32'd0, out_data}, 64'd0);
        check("midrst.out_carry", {63'd0, out_carry}, 64'd0);
        saw_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        check("midrst.no_valid", {63'd0, saw_valid}, 64'd0);

        run_op("post_rst",   32'h0000_0100, 5,  2'b01, 32'h0000_0008, 1'b0, 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
